// File: rtl/dsp_wave_pkg.sv
// Shared types and constants for the waveform player blocks.
//   wave_state_e : playback FSM states
//   ECG_ADDR_W   : default LUT address width (1024 entries)
//   ECG_DATA_W   : default signed sample width
package dsp_wave_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      STALL = 2'd2,
      DONE  = 2'd3
   } wave_state_e;

   localparam int ECG_ADDR_W = 10;
   localparam int ECG_DATA_W = 16;

endpackage

// File: rtl/ecg_wave_player_tick_gen.sv
// Sample-rate divider for the waveform player.
// Down-counter reloaded with the period-minus-1 value; o_tick is the
// terminal-count compare (count == 0).
//   i_clk, i_rst_n : clock, async active-low reset
//   i_clr          : synchronous load of i_ld_val (wins over i_adv)
//   i_ld_val       : period minus 1, in clocks
//   i_adv          : advance the counter; when low the count is frozen
//   o_tick         : terminal count reached
module tick_gen #(
   parameter int DIV_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_clr,
   input  logic [DIV_W-1:0] i_ld_val,
   input  logic             i_adv,
   output logic             o_tick
);

   logic [DIV_W-1:0] cnt_q, cnt_d;

   assign o_tick = (cnt_q == '0);

   always_comb begin
      cnt_d = cnt_q;
      if (i_clr) begin
         cnt_d = i_ld_val;
      end else if (i_adv) begin
         cnt_d = o_tick ? i_ld_val : cnt_q - DIV_W'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

endmodule

// File: rtl/ecg_wave_player.sv
// ECG waveform player: phase-accumulator address sequencer for the waveform
// LUT, with a registered valid/ready sample output and a programmable
// sample-rate divider. One-shot or looping playback.
//   i_clk, i_rst_n       : clock, async active-low reset
//   i_start, i_stop      : start pulse (IDLE/DONE only), abort (highest priority)
//   i_loop, i_step, i_div: playback config, latched at start
//   o_lut_addr/i_lut_data: LUT address (phase MSBs) / combinational LUT data
//   o_sample, o_valid    : registered sample, held until accepted
//   i_ready              : downstream accept
//   o_busy               : RUN or STALL
//   o_wrap               : 1-cycle pulse on phase accumulator carry
//
// state | meaning
// IDLE  | stopped, waiting for i_start
// RUN   | divider running, a tick loads a new sample
// STALL | tick due but previous sample not yet accepted; everything frozen
// DONE  | one-shot pass finished, phase held, waiting for i_start
module ecg_wave_player
   import dsp_wave_pkg::*;
#(
   parameter int ADDR_W  = ECG_ADDR_W,
   parameter int DATA_W  = ECG_DATA_W,
   parameter int PHASE_W = 16,
   parameter int DIV_W   = 16
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_start,
   input  logic               i_stop,
   input  logic               i_loop,
   input  logic [PHASE_W-1:0] i_step,
   input  logic [DIV_W-1:0]   i_div,
   output logic [ADDR_W-1:0]  o_lut_addr,
   input  logic [DATA_W-1:0]  i_lut_data,
   output logic [DATA_W-1:0]  o_sample,
   output logic               o_valid,
   input  logic               i_ready,
   output logic               o_busy,
   output logic               o_wrap
);

   wave_state_e        state_q, state_d;
   logic [PHASE_W-1:0] phase_q, phase_d;
   logic [PHASE_W-1:0] step_l_q, step_l_d;
   logic [DIV_W-1:0]   div_l_q, div_l_d;
   logic               loop_l_q, loop_l_d;
   logic [DATA_W-1:0]  sample_q, sample_d;
   logic               valid_q, valid_d;
   logic               wrap_q, wrap_d;
   // One-shot carry sample emitted; waiting for it to be accepted before DONE.
   logic               fin_q, fin_d;

   logic               tick;
   logic               cnt_clr;
   logic [DIV_W-1:0]   cnt_ld;
   logic               cnt_adv;
   logic [PHASE_W:0]   phase_sum;
   logic               xfer;

   tick_gen #(.DIV_W(DIV_W)) u_tick_gen (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_clr    (cnt_clr),
      .i_ld_val (cnt_ld),
      .i_adv    (cnt_adv),
      .o_tick   (tick)
   );

   assign phase_sum  = {1'b0, phase_q} + {1'b0, step_l_q};
   assign xfer       = valid_q & i_ready;
   assign o_lut_addr = phase_q[PHASE_W-1 -: ADDR_W];
   assign o_sample   = sample_q;
   assign o_valid    = valid_q;
   assign o_wrap     = wrap_q;
   assign o_busy     = (state_q == RUN) || (state_q == STALL);

   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      step_l_d = step_l_q;
      div_l_d  = div_l_q;
      loop_l_d = loop_l_q;
      sample_d = sample_q;
      valid_d  = valid_q;
      wrap_d   = 1'b0;
      fin_d    = fin_q;
      cnt_clr  = 1'b0;
      cnt_ld   = div_l_q;
      cnt_adv  = 1'b0;

      if (i_stop) begin
         state_d = IDLE;
         valid_d = 1'b0;
         phase_d = '0;
         fin_d   = 1'b0;
         cnt_clr = 1'b1;
         cnt_ld  = '0;
      end else begin
         unique case (state_q)
            IDLE, DONE: begin
               if (i_start) begin
                  step_l_d = i_step;
                  div_l_d  = i_div;
                  loop_l_d = i_loop;
                  phase_d  = '0;
                  fin_d    = 1'b0;
                  cnt_clr  = 1'b1;
                  cnt_ld   = i_div;
                  state_d  = RUN;
               end
            end
            RUN: begin
               if (fin_q) begin
                  if (xfer) begin
                     valid_d = 1'b0;
                     fin_d   = 1'b0;
                     state_d = DONE;
                  end
               end else if (tick && valid_q && !i_ready) begin
                  // counter stays at terminal count so the tick fires on return
                  state_d = STALL;
               end else begin
                  cnt_adv = 1'b1;
                  if (tick) begin
                     sample_d = i_lut_data;
                     valid_d  = 1'b1;
                     phase_d  = phase_sum[PHASE_W-1:0];
                     wrap_d   = phase_sum[PHASE_W];
                     if (phase_sum[PHASE_W] && !loop_l_q) fin_d = 1'b1;
                  end else if (xfer) begin
                     valid_d = 1'b0;
                  end
               end
            end
            STALL: begin
               if (i_ready) begin
                  valid_d = 1'b0;
                  state_d = RUN;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= IDLE;
         phase_q  <= '0;
         step_l_q <= '0;
         div_l_q  <= '0;
         loop_l_q <= 1'b0;
         sample_q <= '0;
         valid_q  <= 1'b0;
         wrap_q   <= 1'b0;
         fin_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         step_l_q <= step_l_d;
         div_l_q  <= div_l_d;
         loop_l_q <= loop_l_d;
         sample_q <= sample_d;
         valid_q  <= valid_d;
         wrap_q   <= wrap_d;
         fin_q    <= fin_d;
      end
   end

endmodule

// File: tb/tb_ecg_wave_player.sv
// Self-checking bench for ecg_wave_player: table of playback configurations
// plus hand-written corner sequences; a stream model predicts every sample.
module tb_ecg_wave_player;

   localparam int ADDR_W  = 10;
   localparam int DATA_W  = 16;
   localparam int PHASE_W = 16;
   localparam int DIV_W   = 16;

   logic               i_clk = 1'b0;
   logic               i_rst_n;
   logic               i_start;
   logic               i_stop;
   logic               i_loop;
   logic [PHASE_W-1:0] i_step;
   logic [DIV_W-1:0]   i_div;
   logic [ADDR_W-1:0]  o_lut_addr;
   logic [DATA_W-1:0]  i_lut_data;
   logic [DATA_W-1:0]  o_sample;
   logic               o_valid;
   logic               i_ready;
   logic               o_busy;
   logic               o_wrap;

   ecg_wave_player #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PHASE_W(PHASE_W), .DIV_W(DIV_W)
   ) dut (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_start    (i_start),
      .i_stop     (i_stop),
      .i_loop     (i_loop),
      .i_step     (i_step),
      .i_div      (i_div),
      .o_lut_addr (o_lut_addr),
      .i_lut_data (i_lut_data),
      .o_sample   (o_sample),
      .o_valid    (o_valid),
      .i_ready    (i_ready),
      .o_busy     (o_busy),
      .o_wrap     (o_wrap)
   );

   always #5 i_clk = ~i_clk;

   logic [DATA_W-1:0] lut_mem [0:1023];
   assign i_lut_data = lut_mem[o_lut_addr];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Stream model: sample n reads LUT[(n*step mod 2^16) >> 6] and carries
   // when (n+1)*step crosses a multiple of 2^16.
   function automatic int exp_addr(input int n, input int s);
      longint p;
      p = (longint'(n) * longint'(s)) % 65536;
      return int'(p >> 6);
   endfunction

   function automatic bit exp_carry(input int n, input int s);
      return ((longint'(n) + 1) * longint'(s)) / 65536 != (longint'(n) * longint'(s)) / 65536;
   endfunction

   function automatic int oneshot_len(input int s);
      return (65536 + s - 1) / s;
   endfunction

   bit                mon_en = 1'b0;
   int                got = 0;
   int                m_step = 0;
   bit                wrap_seen = 1'b0;
   bit                prev_hold = 1'b0;
   logic [DATA_W-1:0] prev_s = '0;
   bit                rnd_ready = 1'b0;

   always @(negedge i_clk) begin
      if (mon_en) begin
         if (prev_hold) begin
            chk("stall_hold_valid", longint'(o_valid), 1);
            chk("stall_hold_sample", longint'(o_sample), longint'(prev_s));
         end
         if (o_wrap) wrap_seen = 1'b1;
         if (o_valid && i_ready) begin
            chk("sample_value", longint'(o_sample), longint'(lut_mem[exp_addr(got, m_step)]));
            chk("sample_wrap", longint'(wrap_seen), longint'(exp_carry(got, m_step)));
            got++;
            wrap_seen = 1'b0;
         end
         prev_hold = o_valid && !i_ready;
         prev_s    = o_sample;
      end
   end

   typedef struct {
      int step;
      int div;
      bit loop;
      bit rnd;
      int n;        // samples to check (one-shot: whole pass)
      int exp_lat;  // clocks from start edge to first o_valid
   } vec_t;

   vec_t tbl[$];

   task automatic step_clk();
      @(posedge i_clk);
      #1;
      if (rnd_ready) i_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic start_run(input vec_t v);
      got       = 0;
      wrap_seen = 1'b0;
      prev_hold = 1'b0;
      m_step    = v.step;
      rnd_ready = v.rnd;
      i_ready   = 1'b1;
      i_step    = PHASE_W'(v.step);
      i_div     = DIV_W'(v.div);
      i_loop    = v.loop;
      i_start   = 1'b1;
      mon_en    = 1'b1;
      step_clk();
      i_start   = 1'b0;
   endtask

   task automatic wait_got(input int n, input int budget, output int cyc);
      cyc = 0;
      while (got < n && cyc < budget) begin
         step_clk();
         cyc++;
      end
      chk("sample_count_reached", longint'(got >= n), 1);
   endtask

   task automatic do_stop();
      mon_en    = 1'b0;
      rnd_ready = 1'b0;
      i_stop    = 1'b1;
      step_clk();
      i_stop    = 1'b0;
      chk("stop_busy", longint'(o_busy), 0);
      chk("stop_valid", longint'(o_valid), 0);
      chk("stop_addr", longint'(o_lut_addr), 0);
   endtask

   task automatic run_vec(input vec_t v);
      int lat;
      int cyc;
      start_run(v);
      lat = 0;
      while (!o_valid && lat < 1000) begin
         step_clk();
         lat++;
      end
      chk("first_valid_latency", lat, v.exp_lat);
      wait_got(v.n, 40000, cyc);
      if (!v.rnd) chk("stream_cycles", cyc, longint'((v.n - 1) * (v.div + 1) + 1));
      if (!v.loop && v.step != 0) begin
         repeat (20) step_clk();
         chk("oneshot_done_busy", longint'(o_busy), 0);
         chk("oneshot_no_extra", got, v.n);
         chk("oneshot_valid_low", longint'(o_valid), 0);
      end else begin
         chk("still_busy", longint'(o_busy), 1);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      int cyc;
      logic [DATA_W-1:0] held;

      for (int i = 0; i < 1024; i++) lut_mem[i] = DATA_W'($urandom);
      lut_mem[0] = 16'h8123;

      i_rst_n = 1'b0;
      i_start = 1'b0;
      i_stop  = 1'b0;
      i_loop  = 1'b0;
      i_step  = '0;
      i_div   = '0;
      i_ready = 1'b1;
      repeat (3) @(posedge i_clk);
      #1;
      chk("reset_valid", longint'(o_valid), 0);
      chk("reset_sample", longint'(o_sample), 0);
      chk("reset_wrap", longint'(o_wrap), 0);
      chk("reset_busy", longint'(o_busy), 0);
      chk("reset_addr", longint'(o_lut_addr), 0);
      i_rst_n = 1'b1;
      step_clk();

      tbl.push_back('{step: 64,   div: 0, loop: 1'b0, rnd: 1'b0, n: 1024, exp_lat: 1});
      tbl.push_back('{step: 128,  div: 3, loop: 1'b1, rnd: 1'b0, n: 1100, exp_lat: 4});
      tbl.push_back('{step: 1000, div: 1, loop: 1'b0, rnd: 1'b1, n: 66,   exp_lat: 2});
      tbl.push_back('{step: 4095, div: 0, loop: 1'b1, rnd: 1'b1, n: 70,   exp_lat: 1});
      for (int i = 0; i < 3; i++) begin
         v.step    = int'($urandom_range(300, 4000));
         v.div     = int'($urandom_range(0, 5));
         v.loop    = bit'($urandom_range(0, 1));
         v.rnd     = 1'b1;
         v.n       = v.loop ? 300 : oneshot_len(v.step);
         v.exp_lat = v.div + 1;
         tbl.push_back(v);
      end

      foreach (tbl[i]) begin
         run_vec(tbl[i]);
         do_stop();
         repeat (2) step_clk();
      end

      // reset mid-RUN
      v = '{step: 64, div: 2, loop: 1'b1, rnd: 1'b0, n: 10, exp_lat: 3};
      run_vec(v);
      mon_en  = 1'b0;
      i_rst_n = 1'b0;
      #1;
      chk("midrst_valid", longint'(o_valid), 0);
      chk("midrst_sample", longint'(o_sample), 0);
      chk("midrst_wrap", longint'(o_wrap), 0);
      chk("midrst_busy", longint'(o_busy), 0);
      chk("midrst_addr", longint'(o_lut_addr), 0);
      step_clk();
      i_rst_n = 1'b1;
      repeat (10) step_clk();
      chk("post_rst_valid", longint'(o_valid), 0);
      chk("post_rst_busy", longint'(o_busy), 0);

      // ready held low 10 clocks mid-stream
      v = '{step: 64, div: 0, loop: 1'b1, rnd: 1'b0, n: 20, exp_lat: 1};
      run_vec(v);
      i_ready = 1'b0;
      step_clk();
      held = o_sample;
      repeat (9) step_clk();
      chk("stall10_valid", longint'(o_valid), 1);
      chk("stall10_sample", longint'(o_sample), longint'(held));
      chk("stall10_busy", longint'(o_busy), 1);
      i_ready = 1'b1;
      wait_got(60, 500, cyc);
      do_stop();

      // stop and start together during RUN
      v = '{step: 64, div: 1, loop: 1'b1, rnd: 1'b0, n: 15, exp_lat: 2};
      run_vec(v);
      mon_en  = 1'b0;
      i_stop  = 1'b1;
      i_start = 1'b1;
      i_step  = 16'd999;
      step_clk();
      i_stop  = 1'b0;
      i_start = 1'b0;
      chk("stopstart_busy", longint'(o_busy), 0);
      chk("stopstart_valid", longint'(o_valid), 0);
      chk("stopstart_addr", longint'(o_lut_addr), 0);
      repeat (5) step_clk();
      chk("stopstart_idle", longint'(o_busy), 0);
      v = '{step: 64, div: 1, loop: 1'b0, rnd: 1'b0, n: 1024, exp_lat: 2};
      run_vec(v);
      do_stop();

      // step=0: LUT[0] forever, no wrap, start while busy ignored
      v = '{step: 0, div: 0, loop: 1'b0, rnd: 1'b0, n: 50, exp_lat: 1};
      run_vec(v);
      i_step  = 16'd64;
      i_div   = 16'd3;
      i_loop  = 1'b1;
      i_start = 1'b1;
      step_clk();
      i_start = 1'b0;
      wait_got(90, 500, cyc);
      chk("step0_busy_start_ignored", longint'(o_busy), 1);
      chk("step0_addr", longint'(o_lut_addr), 0);
      do_stop();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
